vga_frame_reader: RTL and testbench

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

---
 rtl/vga_frame_reader.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_vga_frame_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
//
// Fetches one frame of RGB565 pixels from word-addressed memory in fixed-size
// bursts, buffers them in a pixel FIFO and hands them one per request to the
// VGA timing stage. A rising edge on vga_vs marks a new frame: the FIFO is
// flushed and fetching restarts at BASE_ADDR. A burst that is in flight when
// the frame restarts is drained without being stored.
//
// Ports
//   vga_clk     pixel clock, all logic on its rising edge
//   sys_rst     asynchronous, active-high reset
//   vga_vs      field sync from the timing stage (low during sync)
//   data_req    pixel request from the timing stage
//   pixel_data  registered RGB565 pixel (latency 1 from data_req)
//   rd_req      burst request to memory, held until rd_ack
//   rd_addr     burst start word address, stable while rd_req is high
//   rd_ack      memory accepted the request
//   rd_valid    memory data beat strobe
//   rd_data     memory data beat
//   underflow   set when a pixel is requested from an empty FIFO, sticky
//               until the next frame start
//   fifo_level  current FIFO occupancy
// ---------------------------------------------------------------------------
module vga_frame_reader #(
    parameter int H_DISP     = 1024,
    parameter int V_DISP     = 768,
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 512,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_W     = 20
) (
    input  logic                        vga_clk,
    input  logic                        sys_rst,
    input  logic                        vga_vs,
    input  logic                        data_req,
    output logic [15:0]                 pixel_data,
    output logic                        rd_req,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic                        rd_ack,
    input  logic                        rd_valid,
    input  logic [15:0]                 rd_data,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int TOTAL   = H_DISP * V_DISP;
    localparam int WORDS_W = $clog2(TOTAL + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int BC_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [ADDR_W-1:0]  BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]  BURST_A  = ADDR_W'(BURST_LEN);
    localparam logic [WORDS_W-1:0] TOTAL_WD = WORDS_W'(TOTAL);
    localparam logic [WORDS_W-1:0] BURST_WD = WORDS_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]   DEPTH_L  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]   BURST_L  = LVL_W'(BURST_LEN);
    localparam logic [BC_W-1:0]    LAST_BC  = BC_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DATA    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                disc_pend_q, disc_pend_d;
    logic                vs_dly_q, vs_dly_d;
    logic                fetch_en_q, fetch_en_d;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic [WORDS_W-1:0]  words_q, words_d;
    logic [BC_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                rd_req_q, rd_req_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [15:0]         pixel_q, pixel_d;
    logic                underflow_q, underflow_d;
    logic [15:0]         mem_q [FIFO_DEPTH];

    logic frame_start;
    logic fifo_empty;
    logic pop;
    logic space_ok;
    logic last_beat;
    logic push;
    logic beat_adv;
    logic burst_done;
    logic load_req;

    // Frame-start detection and FIFO/burst qualifiers shared by the FSM and datapath.
    always_comb begin
        frame_start = vga_vs & ~vs_dly_q;
        fifo_empty  = (level_q == LVL_W'(0));
        pop         = data_req & ~fifo_empty;
        // A new burst is only requested when all of its beats are guaranteed room.
        space_ok    = ((DEPTH_L - level_q) >= BURST_L);
        last_beat   = (beat_cnt_q == LAST_BC);
    end

    // FSM state register; the pending-discard flag travels with the state.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            disc_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            disc_pend_q <= disc_pend_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d     = state_q;
        disc_pend_d = disc_pend_q;
        case (state_q)
            S_IDLE: begin
                // No new request on the frame-start cycle: address/count are being reloaded.
                if (fetch_en_q && !frame_start && (words_q != WORDS_W'(0)) && space_ok) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // The request already on the bus must still be acknowledged; remember
                // a frame restart so its data is thrown away.
                if (rd_ack) begin
                    state_d     = (disc_pend_q || frame_start) ? S_DISCARD : S_DATA;
                    disc_pend_d = 1'b0;
                end else begin
                    state_d     = S_REQ;
                    disc_pend_d = disc_pend_q | frame_start;
                end
            end
            S_DATA: begin
                if (rd_valid && last_beat) begin
                    state_d = S_IDLE;
                end else if (frame_start) begin
                    state_d = S_DISCARD;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DISCARD: begin
                if (rd_valid && last_beat) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DISCARD;
                end
            end
            default: begin
                state_d     = S_IDLE;
                disc_pend_d = 1'b0;
            end
        endcase
    end

    // FSM output decode: FIFO push, beat counting, burst completion, request launch.
    always_comb begin
        push       = 1'b0;
        beat_adv   = 1'b0;
        burst_done = 1'b0;
        load_req   = 1'b0;
        case (state_q)
            S_IDLE: begin
                load_req = (state_d == S_REQ);
            end
            S_REQ: begin
                load_req = 1'b0;
            end
            S_DATA: begin
                // A beat that coincides with a frame restart belongs to the old frame.
                beat_adv   = rd_valid;
                push       = rd_valid & ~frame_start;
                burst_done = rd_valid & last_beat & ~frame_start;
            end
            S_DISCARD: begin
                beat_adv = rd_valid;
            end
            default: begin
                load_req = 1'b0;
            end
        endcase
        rd_req_d = (state_d == S_REQ);
    end

    // Datapath next-state: fetch pointer, word budget, beat count, FIFO and pixel output.
    always_comb begin
        vs_dly_d   = vga_vs;
        fetch_en_d = fetch_en_q | frame_start;

        if (frame_start) begin
            fetch_addr_d = BASE_A;
            words_d      = TOTAL_WD;
        end else if (burst_done) begin
            fetch_addr_d = fetch_addr_q + BURST_A;
            words_d      = words_q - BURST_WD;
        end else begin
            fetch_addr_d = fetch_addr_q;
            words_d      = words_q;
        end

        // Beat count survives a frame restart so a discarded burst ends on time.
        if (beat_adv) begin
            if (last_beat) begin
                beat_cnt_d = BC_W'(0);
            end else begin
                beat_cnt_d = beat_cnt_q + BC_W'(1);
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end

        if (load_req) begin
            req_addr_d = fetch_addr_q;
        end else begin
            req_addr_d = req_addr_q;
        end

        if (frame_start) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            level_d  = LVL_W'(0);
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        end

        if (data_req) begin
            if (pop) begin
                pixel_d = mem_q[rd_ptr_q];
            end else begin
                pixel_d = 16'h0000;
            end
        end else begin
            pixel_d = pixel_q;
        end

        if (frame_start) begin
            underflow_d = 1'b0;
        end else if (data_req && fifo_empty) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vs_dly_q     <= 1'b1;
            fetch_en_q   <= 1'b0;
            fetch_addr_q <= BASE_A;
            words_q      <= WORDS_W'(0);
            beat_cnt_q   <= BC_W'(0);
            req_addr_q   <= BASE_A;
            rd_req_q     <= 1'b0;
            wr_ptr_q     <= PTR_W'(0);
            rd_ptr_q     <= PTR_W'(0);
            level_q      <= LVL_W'(0);
            pixel_q      <= 16'h0000;
            underflow_q  <= 1'b0;
        end else begin
            vs_dly_q     <= vs_dly_d;
            fetch_en_q   <= fetch_en_d;
            fetch_addr_q <= fetch_addr_d;
            words_q      <= words_d;
            beat_cnt_q   <= beat_cnt_d;
            req_addr_q   <= req_addr_d;
            rd_req_q     <= rd_req_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            pixel_q      <= pixel_d;
            underflow_q  <= underflow_d;
        end
    end

    // Pixel FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge vga_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rd_data;
        end
    end

    assign pixel_data = pixel_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = req_addr_q;
    assign underflow  = underflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// ---------------------------------------------------------------------------
// Testbench for vga_frame_reader (H_DISP=8, V_DISP=4, BURST_LEN=4,
// FIFO_DEPTH=16, BASE_ADDR=0x100). A memory model returns data equal to the
// word address. The reference model works at frame level: within a frame the
// n-th pixel popped is BASE+n if that many words have already arrived, the
// n-th request starts at BASE+4n, and a burst requested before the latest
// frame start contributes nothing.
// ---------------------------------------------------------------------------
module tb_vga_frame_reader;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int BL    = 4;
    localparam int FD    = 16;
    localparam int BASE  = 32'h100;
    localparam int AW    = 20;
    localparam int TOTAL = H * V;

    logic          vga_clk = 1'b0;
    logic          sys_rst;
    logic          vga_vs;
    logic          data_req;
    logic [15:0]   pixel_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [15:0]   rd_data;
    logic          underflow;
    logic [4:0]    fifo_level;

    int checks = 0;
    int errors = 0;

    vga_frame_reader #(
        .H_DISP(H), .V_DISP(V), .BURST_LEN(BL), .FIFO_DEPTH(FD),
        .BASE_ADDR(BASE), .ADDR_W(AW)
    ) dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst), .vga_vs(vga_vs), .data_req(data_req),
        .pixel_data(pixel_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .underflow(underflow),
        .fifo_level(fifo_level)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    // ---------------- memory model ----------------
    bit          mem_ack_en;
    int          stray_total;
    int          stray_done;
    int          mem_phase;
    int          mem_beat;
    logic [AW-1:0] mem_addr;

    initial begin
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = 16'h0000;
        mem_phase = 0; mem_beat = 0; mem_addr = '0; stray_done = 0;
        forever begin
            @(posedge vga_clk);
            #1;
            rd_ack   = 1'b0;
            rd_valid = 1'b0;
            if (sys_rst) begin
                mem_phase = 0;
            end else begin
                if (mem_phase == 1) begin
                    mem_phase = 2;
                    mem_beat  = 0;
                end
                if (mem_phase == 2) begin
                    if ($urandom_range(0, 3) != 0) begin
                        rd_valid = 1'b1;
                        rd_data  = 16'(mem_addr + AW'(mem_beat));
                        mem_beat++;
                        if (mem_beat == BL) mem_phase = 0;
                    end
                end else if (stray_done < stray_total) begin
                    rd_valid = 1'b1;
                    rd_data  = 16'hBEEF;
                    stray_done++;
                end else if (rd_req && mem_ack_en && ($urandom_range(0, 1) == 0)) begin
                    rd_ack    = 1'b1;
                    mem_addr  = rd_addr;
                    mem_phase = 1;
                end
            end
        end
    end

    // ---------------- input/output sampler (values seen by the next edge) ----------------
    logic          s_vs, s_req, s_ack, s_valid, s_dreq;
    logic [AW-1:0] s_addr;

    always @(negedge vga_clk) begin
        s_vs    = vga_vs;
        s_req   = rd_req;
        s_ack   = rd_ack;
        s_valid = rd_valid;
        s_dreq  = data_req;
        s_addr  = rd_addr;
    end

    // ---------------- reference model ----------------
    int          gen, delivered, popped, req_cnt, req_tag, burst_tag, beats;
    bit          req_tagged, burst_live, m_under, m_en, vs_prev, m_fs;
    logic [15:0] pix_q[$];

    always @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            delivered = 0; popped = 0; req_cnt = 0; beats = 0;
            req_tagged = 1'b0; burst_live = 1'b0; m_under = 1'b0;
            m_en = 1'b0; vs_prev = 1'b1;
            pix_q.delete();
        end else begin
            m_fs    = s_vs && !vs_prev;
            vs_prev = s_vs;
            // New request: it belongs to the frame current before any restart at this edge.
            if (s_req && !req_tagged) begin
                req_tagged = 1'b1;
                req_tag    = gen;
                chk(m_en && (req_cnt < TOTAL / BL), "req_budget", req_cnt, TOTAL / BL - 1);
                chk(s_addr == AW'(BASE + BL * req_cnt), "rd_addr", int'(s_addr), BASE + BL * req_cnt);
                chk((delivered - popped) <= FD - BL, "req_space", delivered - popped, FD - BL);
                req_cnt++;
            end
            if (m_fs) begin
                gen++;
                delivered = 0; popped = 0; req_cnt = 0;
                m_under = 1'b0; m_en = 1'b1;
            end
            if (s_dreq) begin
                if (delivered > popped) begin
                    pix_q.push_back(16'(BASE + popped));
                    popped++;
                end else begin
                    pix_q.push_back(16'h0000);
                    m_under = 1'b1;
                end
            end
            if (s_valid && burst_live) begin
                if (burst_tag == gen) delivered++;
                beats++;
                if (beats == BL) burst_live = 1'b0;
            end
            if (s_req && s_ack) begin
                burst_live = 1'b1;
                burst_tag  = req_tag;
                beats      = 0;
                req_tagged = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [15:0] last_pix = 16'h0000;

    always @(negedge vga_clk) begin
        if (sys_rst) begin
            last_pix = 16'h0000;
            chk(pixel_data == 16'h0000, "rst_pixel", pixel_data, 0);
            chk(fifo_level == 5'd0, "rst_level", fifo_level, 0);
            chk(underflow == 1'b0, "rst_underflow", underflow, 0);
            chk(rd_req == 1'b0, "rst_rd_req", rd_req, 0);
            chk(rd_addr == AW'(BASE), "rst_rd_addr", rd_addr, BASE);
        end else begin
            if (pix_q.size() > 0) begin
                last_pix = pix_q.pop_front();
                chk(pixel_data == last_pix, "pixel", pixel_data, last_pix);
            end else begin
                chk(pixel_data == last_pix, "pixel_hold", pixel_data, last_pix);
            end
            chk(int'(fifo_level) == delivered - popped, "fifo_level", fifo_level, delivered - popped);
            chk(underflow == m_under, "underflow", underflow, m_under);
            if (!m_en) chk(rd_req == 1'b0, "req_before_frame", rd_req, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic frame_start();
        data_req = 1'b0;
        vga_vs   = 1'b0;
        cycle(2);
        vga_vs   = 1'b1;
        cycle(1);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            data_req = ($urandom_range(0, 1) == 1);
            cycle(1);
        end
        data_req = 1'b0;
    endtask

    initial begin
        bit got;
        sys_rst = 1'b1; vga_vs = 1'b1; data_req = 1'b0;
        mem_ack_en = 1'b1; stray_total = 0; gen = 0;
        cycle(3);
        chk(rd_req == 1'b0, "reset_rd_req", rd_req, 0);
        chk(rd_addr == AW'(BASE), "reset_rd_addr", rd_addr, BASE);
        sys_rst = 1'b0;
        cycle(6);
        chk(rd_req == 1'b0, "no_fetch_before_vs", rd_req, 0);

        // Fill: four bursts then stop with the FIFO full.
        frame_start();
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (fifo_level == 5'd16) got = 1'b1;
            else cycle(1);
        end
        chk(got, "fill_to_16", fifo_level, 16);
        cycle(6);
        chk(fifo_level == 5'd16, "full_no_fifth_req", fifo_level, 16);

        // Continuous drain of eight pixels, then random consumption to end of frame.
        data_req = 1'b1;
        cycle(8);
        data_req = 1'b0;
        cycle(2);
        chk(underflow == 1'b0, "drain8_no_underflow", underflow, 0);
        random_run(200);
        cycle(6);
        chk(req_cnt == TOTAL / BL, "frame_req_count", req_cnt, TOTAL / BL);

        // Underflow with memory stalled, cleared by the next frame start.
        mem_ack_en = 1'b0;
        frame_start();
        cycle(3);
        data_req = 1'b1;
        cycle(1);
        data_req = 1'b0;
        cycle(1);
        chk(pixel_data == 16'h0000, "uf_pixel", pixel_data, 0);
        chk(underflow == 1'b1, "uf_flag", underflow, 1);
        frame_start();
        chk(underflow == 1'b0, "uf_clear", underflow, 0);
        mem_ack_en = 1'b1;

        // Frame restarts at random points across REQ, DATA and DISCARD.
        for (int k = 0; k < 25; k++) begin
            random_run($urandom_range(0, 30));
            frame_start();
        end

        // Reset in the middle of a burst, followed by stray beats.
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (mem_phase == 2) got = 1'b1;
            else cycle(1);
        end
        chk(got, "reach_data_phase", mem_phase, 2);
        sys_rst = 1'b1;
        cycle(1);
        chk(rd_req == 1'b0, "midburst_rst_req", rd_req, 0);
        chk(fifo_level == 5'd0, "midburst_rst_level", fifo_level, 0);
        sys_rst = 1'b0;
        stray_total = 3;
        cycle(8);
        chk(fifo_level == 5'd0, "stray_beats_level", fifo_level, 0);

        // One more full frame.
        frame_start();
        random_run(200);
        cycle(6);
        chk(req_cnt == TOTAL / BL, "last_frame_req_count", req_cnt, TOTAL / BL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
